// File: rtl/pea_pkg.sv
// Shared types and default sizing for the streaming PEA.
// The output collector state enum lives here so that status/debug logic can decode it.
package pea_pkg;

    localparam int PEA_N_BITS     = 32;
    localparam int OUT_FIFO_DEPTH = 4;
    localparam int OUT_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } out_coll_state_t;

endpackage

// File: rtl/s_stream_fifo.sv
// Generic synchronous stream FIFO with flush and a registered head word.
// The head register makes a pushed word visible one cycle later and keeps data_o glitch-free.
module s_stream_fifo #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [N_BITS-1:0] data_i,
    input  logic              pop_i,
    output logic [N_BITS-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [N_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [N_BITS-1:0] head_q, head_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign data_o  = head_q;

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Storage array carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            head_d   = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
            // The incoming word becomes head only when nothing older remains behind it.
            if (push_ok && (empty_o || (pop_ok && occ_q == OCC_W'(1)))) begin
                head_d = data_i;
            end else if (pop_ok && occ_q > OCC_W'(1)) begin
                head_d = mem_q[rd_ptr_q + PTR_W'(1)];
            end else if (pop_ok) begin
                head_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/s_pea_out_collector.sv
// Output sink of the streaming PEA: buffers output-PE results, stalls the array when full,
// and tracks the programmed element count to mark the last element and kernel completion.
module s_pea_out_collector
    import pea_pkg::*;
#(
    parameter int N_BITS = PEA_N_BITS,
    parameter int DEPTH  = OUT_FIFO_DEPTH,
    parameter int CNT_W  = OUT_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mage_done_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_elems_i,
    input  logic [N_BITS-1:0] pe_res_i,
    input  logic              pe_valid_i,
    output logic              pea_ready_o,
    output logic [N_BITS-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              done_o
);

    out_coll_state_t  state_q, state_d;
    logic [CNT_W-1:0] n_elems_q, n_elems_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Ready depends only on registers, so downstream back-pressure never reaches the PEs combinationally.
    assign pea_ready_o = (state_q == RUN) && !fifo_full;
    assign out_valid_o = !fifo_empty;
    assign push        = pe_valid_i && pea_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_last_o  = out_valid_o && (out_cnt_q == n_elems_q - CNT_W'(1));
    assign done_o      = (state_q == DONE);

    s_stream_fifo #(
        .N_BITS (N_BITS),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (mage_done_i),
        .push_i  (push),
        .data_i  (pe_res_i),
        .pop_i   (pop),
        .data_o  (out_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        n_elems_d = n_elems_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (mage_done_i) begin
            state_d   = IDLE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (push) begin
                in_cnt_d = in_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_elems_d = n_elems_i;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = (n_elems_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push && in_cnt_q == n_elems_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_cnt_q == n_elems_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            n_elems_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            n_elems_q <= n_elems_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_s_pea_out_collector.sv
// Bench for s_pea_out_collector: directed scenarios plus randomized kernels, checked
// every cycle against a queue-based model of the collector's observable behaviour.
module tb_s_pea_out_collector;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        mage_done_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] n_elems_i = '0;
    logic [31:0] pe_res_i = '0;
    logic        pe_valid_i = 1'b0;
    logic        pea_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        out_last_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    // Reference model: kernel phase, expected FIFO contents and element counts.
    int          m_state = M_IDLE;
    int          m_n = 0;
    int          m_in = 0;
    int          m_out = 0;
    logic [31:0] m_q[$];
    bit          m_push_ev = 0;
    logic [31:0] pop_log[$];

    s_pea_out_collector dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mage_done_i (mage_done_i),
        .start_i     (start_i),
        .n_elems_i   (n_elems_i),
        .pe_res_i    (pe_res_i),
        .pe_valid_i  (pe_valid_i),
        .pea_ready_o (pea_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_ready();
        return (m_state == M_RUN) && (m_q.size() < 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_n = 0;
        m_in = 0;
        m_out = 0;
        m_q.delete();
        m_push_ev = 0;
    endtask

    task automatic model_edge();
        int  st;
        bit  rdy;
        bit  vld;
        st  = m_state;
        rdy = m_ready();
        vld = (m_q.size() != 0);
        m_push_ev = 0;
        if (mage_done_i) begin
            model_reset();
            return;
        end
        if (vld && out_ready_i) begin
            void'(m_q.pop_front());
            m_out++;
            if (st == M_DRAIN && m_out == m_n) m_state = M_DONE;
        end
        if (pe_valid_i && rdy) begin
            m_q.push_back(pe_res_i);
            m_in++;
            m_push_ev = 1;
            if (m_in == m_n) m_state = M_DRAIN;
        end
        if (st == M_IDLE && start_i) begin
            m_n   = int'(n_elems_i);
            m_in  = 0;
            m_out = 0;
            m_state = (m_n == 0) ? M_DONE : M_RUN;
        end
    endtask

    task automatic compare();
        bit vld;
        vld = (m_q.size() != 0);
        chk("pea_ready", 32'(pea_ready_o), 32'(m_ready()));
        chk("out_valid", 32'(out_valid_o), 32'(vld));
        if (vld) chk("out_data", out_data_o, m_q[0]);
        chk("out_last", 32'(out_last_o), 32'(vld && (m_out == m_n - 1)));
        chk("done", 32'(done_o), 32'(m_state == M_DONE));
    endtask

    // One clock: log the DUT-side pop, advance the model at the edge, compare just after.
    task automatic cycle();
        if (out_valid_o && out_ready_i) pop_log.push_back(out_data_o);
        @(posedge clk_i);
        model_edge();
        #1;
        compare();
    endtask

    task automatic abort_kernel();
        mage_done_i = 1'b1;
        start_i = 1'b0;
        pe_valid_i = 1'b0;
        cycle();
        mage_done_i = 1'b0;
        chk("abort_valid", 32'(out_valid_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
    endtask

    task automatic start_kernel(input int n);
        start_i = 1'b1;
        n_elems_i = 16'(n);
        cycle();
        start_i = 1'b0;
    endtask

    // Source behaves like the output PE: value base+idx is held until accepted.
    task automatic feed(input int base, inout int idx, input int vpct, input int rpct,
                        input int max_cyc, input bit stop_at_done);
        for (int k = 0; k < max_cyc; k++) begin
            if (stop_at_done && m_state == M_DONE) break;
            pe_valid_i  = ($urandom_range(99) < vpct);
            pe_res_i    = 32'(base + idx);
            out_ready_i = ($urandom_range(99) < rpct);
            cycle();
            if (m_push_ev) idx++;
        end
        pe_valid_i = 1'b0;
    endtask

    initial begin
        int idx;
        int n;
        bit aborted;

        #1;
        chk("reset_ready", 32'(pea_ready_o), 32'd0);
        chk("reset_valid", 32'(out_valid_o), 32'd0);
        chk("reset_data", out_data_o, 32'd0);
        chk("reset_last", 32'(out_last_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        model_reset();
        cycle();

        // Streaming 10..14 at full rate.
        pop_log.delete();
        start_kernel(5);
        idx = 0;
        feed(10, idx, 100, 100, 40, 1'b1);
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_count", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < pop_log.size() && i < 5; i++) chk("t1_seq", pop_log[i], 32'(10 + i));
        abort_kernel();

        // Back-pressure: fill, stall with value 4 held, then release.
        pop_log.delete();
        start_kernel(8);
        idx = 0;
        feed(0, idx, 100, 0, 7, 1'b0);
        chk("t2_stall_ready", 32'(pea_ready_o), 32'd0);
        chk("t2_held_idx", 32'(idx), 32'd4);
        feed(0, idx, 100, 100, 40, 1'b1);
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_count", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < pop_log.size() && i < 8; i++) chk("t2_seq", pop_log[i], 32'(i));
        abort_kernel();

        // Full FIFO with a single-cycle pop: ready returns only after the pop.
        start_kernel(6);
        idx = 0;
        feed(100, idx, 100, 0, 6, 1'b0);
        chk("t3_full_ready", 32'(pea_ready_o), 32'd0);
        pe_valid_i = 1'b1;
        pe_res_i = 32'(100 + idx);
        out_ready_i = 1'b1;
        cycle();
        out_ready_i = 1'b0;
        chk("t3_ready_back", 32'(pea_ready_o), 32'd1);
        feed(100, idx, 100, 100, 40, 1'b1);
        chk("t3_done", 32'(done_o), 32'd1);
        abort_kernel();

        // Zero-length kernel.
        start_kernel(0);
        chk("t4_done", 32'(done_o), 32'd1);
        idx = 0;
        feed(0, idx, 100, 100, 4, 1'b0);
        chk("t4_no_push", 32'(idx), 32'd0);
        abort_kernel();

        // Abort with two buffered entries, then a one-element kernel.
        start_kernel(6);
        idx = 0;
        feed(50, idx, 100, 0, 2, 1'b0);
        chk("t5_buffered", 32'(out_valid_o), 32'd1);
        abort_kernel();
        pop_log.delete();
        start_kernel(1);
        pe_valid_i = 1'b1;
        pe_res_i = 32'hA5;
        out_ready_i = 1'b1;
        cycle();
        pe_valid_i = 1'b0;
        chk("t5_last", 32'(out_last_o), 32'd1);
        for (int k = 0; k < 10 && m_state != M_DONE; k++) cycle();
        chk("t5_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("t5_data", pop_log[0], 32'hA5);
        chk("t5_done", 32'(done_o), 32'd1);
        abort_kernel();

        // Asynchronous reset between clock edges.
        start_kernel(7);
        idx = 0;
        feed(200, idx, 100, 0, 3, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_ready", 32'(pea_ready_o), 32'd0);
        chk("arst_valid", 32'(out_valid_o), 32'd0);
        chk("arst_data", out_data_o, 32'd0);
        chk("arst_last", 32'(out_last_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        // Randomized kernels with stray starts and occasional aborts.
        for (int kr = 0; kr < 25; kr++) begin
            n = $urandom_range(12);
            start_kernel(n);
            idx = 0;
            aborted = 0;
            for (int k = 0; k < 300 && m_state != M_DONE; k++) begin
                pe_valid_i  = ($urandom_range(99) < 60);
                pe_res_i    = 32'(1000 * kr + idx);
                out_ready_i = ($urandom_range(99) < 60);
                start_i     = ($urandom_range(9) == 0);
                n_elems_i   = 16'($urandom_range(15));
                mage_done_i = ($urandom_range(99) < 2);
                aborted     = mage_done_i;
                cycle();
                mage_done_i = 1'b0;
                start_i = 1'b0;
                if (m_push_ev) idx++;
                if (aborted) break;
            end
            if (!aborted) chk("rand_done", 32'(done_o), 32'd1);
            abort_kernel();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
